// File: rtl/sys_counter_pkg.sv
// Shared constants and helpers for the system counter bank.
package sys_counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;
    localparam int MAX_CH    = 16;

    // Channel index width; a single-channel bank still gets a 1-bit index.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sys_counter_ch.sv
// One counter channel: count register, sticky overflow, registered compare pulse.
// Priority inside the channel: clr > ld > inc.
module sys_counter_ch
    import sys_counter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             inc,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             cmp_hit
);

    logic             at_max;
    logic             hold;
    logic             do_inc;
    logic [WIDTH-1:0] count_nxt;

    assign at_max    = &count;
    assign hold      = at_max && (SATURATE == MODE_SAT);
    assign do_inc    = inc && !clr && !ld;
    assign count_nxt = hold ? count : count + WIDTH'(1);

    // Count/ovf update plus a compare pulse only when an increment actually moves the count.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            count   <= '0;
            ovf     <= 1'b0;
            cmp_hit <= 1'b0;
        end else begin
            cmp_hit <= do_inc && !hold && (count_nxt == cmp_val);
            if (clr) begin
                count <= '0;
                ovf   <= 1'b0;
            end else if (ld) begin
                count <= ld_val;
            end else if (inc) begin
                count <= count_nxt;
                if (at_max) ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sys_counter_bank.sv
// Multi-channel system counter bank with a one-cycle-latency read port.
// Optional shared prescaler is enabled by defining SYS_COUNTER_PRESCALER_EN;
// otherwise every enabled cycle is a count tick.
module sys_counter_bank
    import sys_counter_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int WIDTH    = 32,
    parameter int SATURATE = MODE_WRAP,
`ifdef SYS_COUNTER_PRESCALER_EN
    parameter int PRESC_W  = 8,
`endif
    parameter int CH_W     = ch_width(NUM_CH)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              En,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] ch_clr,
    input  logic              ld_valid,
    input  logic [CH_W-1:0]   ld_ch,
    input  logic [WIDTH-1:0]  ld_val,
    input  logic [WIDTH-1:0]  cmp_val,
`ifdef SYS_COUNTER_PRESCALER_EN
    input  logic [PRESC_W-1:0] presc_div,
`endif
    input  logic              rd_req,
    input  logic [CH_W-1:0]   rd_ch,
    output logic              rd_valid,
    output logic [WIDTH-1:0]  rd_data,
    output logic [NUM_CH-1:0] ovf,
    output logic [NUM_CH-1:0] cmp_hit
);

    logic             tick;
    logic [WIDTH-1:0] count [NUM_CH];
    logic [WIDTH-1:0] rd_mux;

`ifdef SYS_COUNTER_PRESCALER_EN
    logic [PRESC_W-1:0] presc;

    assign tick = (presc == presc_div);

    // Shared prescaler: runs 0..presc_div while En is high, parked at 0 otherwise.
    // The >= return keeps it bounded if presc_div is lowered mid-count.
    always_ff @(posedge Clk) begin
        if (Rst || !En) begin
            presc <= '0;
        end else if (presc >= presc_div) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end
`else
    assign tick = 1'b1;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ld_sel;
        logic inc_sel;

        // Out-of-range ld_ch values match no channel, so such loads fall away.
        assign ld_sel  = ld_valid && (ld_ch == CH_W'(i));
        assign inc_sel = En && ch_en[i] && tick;

        sys_counter_ch #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_ch (
            .Clk     (Clk),
            .Rst     (Rst),
            .inc     (inc_sel),
            .clr     (ch_clr[i]),
            .ld      (ld_sel),
            .ld_val  (ld_val),
            .cmp_val (cmp_val),
            .count   (count[i]),
            .ovf     (ovf[i]),
            .cmp_hit (cmp_hit[i])
        );
    end

    // Read mux over current (pre-update) counts; unmatched channel index reads 0.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) rd_mux = count[i];
        end
    end

    // Read response register; data holds between requests.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_sys_counter_bank.sv
// Scoreboard bench for sys_counter_bank: a wrapping and a saturating 8-bit
// instance share stimulus; a behavioural model predicts each cycle's outputs.
module tb_sys_counter_bank;
    import sys_counter_pkg::*;

    localparam int NCH  = 5;
    localparam int W    = 8;
    localparam int CW   = ch_width(NCH);
    localparam int MAXV = (1 << W) - 1;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic            Rst, En, ld_valid, rd_req;
    logic [NCH-1:0]  ch_en, ch_clr;
    logic [CW-1:0]   ld_ch, rd_ch;
    logic [W-1:0]    ld_val, cmp_val;
`ifdef SYS_COUNTER_PRESCALER_EN
    logic [7:0]      presc_div;
`endif

    logic            rv   [2];
    logic [W-1:0]    rdat [2];
    logic [NCH-1:0]  ovf_o [2];
    logic [NCH-1:0]  hit_o [2];

    sys_counter_bank #(.NUM_CH(NCH), .WIDTH(W), .SATURATE(MODE_WRAP)) dut_w (
        .Clk(Clk), .Rst(Rst), .En(En), .ch_en(ch_en), .ch_clr(ch_clr),
        .ld_valid(ld_valid), .ld_ch(ld_ch), .ld_val(ld_val), .cmp_val(cmp_val),
`ifdef SYS_COUNTER_PRESCALER_EN
        .presc_div(presc_div),
`endif
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_valid(rv[0]), .rd_data(rdat[0]),
        .ovf(ovf_o[0]), .cmp_hit(hit_o[0])
    );

    sys_counter_bank #(.NUM_CH(NCH), .WIDTH(W), .SATURATE(MODE_SAT)) dut_s (
        .Clk(Clk), .Rst(Rst), .En(En), .ch_en(ch_en), .ch_clr(ch_clr),
        .ld_valid(ld_valid), .ld_ch(ld_ch), .ld_val(ld_val), .cmp_val(cmp_val),
`ifdef SYS_COUNTER_PRESCALER_EN
        .presc_div(presc_div),
`endif
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_valid(rv[1]), .rd_data(rdat[1]),
        .ovf(ovf_o[1]), .cmp_hit(hit_o[1])
    );

    typedef struct packed {
        logic [1:0]          rv;
        logic [1:0][W-1:0]   rd;
        logic [1:0][NCH-1:0] ovf;
        logic [1:0][NCH-1:0] hit;
    } st_t;

    st_t          st_q [$];
    logic [W-1:0] rdq  [2][$];

    int checks = 0;
    int errors = 0;

    // reference model state
    int           mcnt  [2][NCH];
    bit           movf  [2][NCH];
    logic [W-1:0] mlast [2];
    int           pcnt;

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, d, $time, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, read data popped when rd_valid shows.
    initial begin
        st_t          e;
        logic [W-1:0] x;
        forever begin
            @(posedge Clk);
            #1;
            if (st_q.size() == 0) continue;
            e = st_q.pop_front();
            for (int d = 0; d < 2; d++) begin
                chk("rd_valid", d, 64'(rv[d]), 64'(e.rv[d]));
                if (rv[d] === 1'b1) begin
                    if (rdq[d].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rd_unexpected dut%0d t=%0t: got rd_valid=1 expected no pending read", d, $time);
                    end else begin
                        x = rdq[d].pop_front();
                        chk("rd_data", d, 64'(rdat[d]), 64'(x));
                    end
                end else begin
                    chk("rd_hold", d, 64'(rdat[d]), 64'(e.rd[d]));
                end
                chk("ovf", d, 64'(ovf_o[d]), 64'(e.ovf[d]));
                chk("cmp_hit", d, 64'(hit_o[d]), 64'(e.hit[d]));
            end
        end
    end

    // Predict the outputs that follow the coming clock edge, then advance one cycle.
    task automatic step();
        st_t  e;
        int   nv;
        bit   tick;
        e = '0;
        if (Rst) begin
            for (int d = 0; d < 2; d++) begin
                mlast[d] = '0;
                for (int i = 0; i < NCH; i++) begin
                    mcnt[d][i] = 0;
                    movf[d][i] = 1'b0;
                end
            end
            pcnt = 0;
        end else begin
            tick = 1'b1;
`ifdef SYS_COUNTER_PRESCALER_EN
            if (!En) begin
                tick = 1'b0;
                pcnt = 0;
            end else begin
                tick = (pcnt == int'(presc_div));
                pcnt = tick ? 0 : pcnt + 1;
            end
`endif
            for (int d = 0; d < 2; d++) begin
                if (rd_req) begin
                    mlast[d] = (int'(rd_ch) < NCH) ? W'(mcnt[d][rd_ch]) : '0;
                    rdq[d].push_back(mlast[d]);
                    e.rv[d] = 1'b1;
                end
                e.rd[d] = mlast[d];
                for (int i = 0; i < NCH; i++) begin
                    if (ch_clr[i]) begin
                        mcnt[d][i] = 0;
                        movf[d][i] = 1'b0;
                    end else if (ld_valid && int'(ld_ch) == i) begin
                        mcnt[d][i] = int'(ld_val);
                    end else if (En && ch_en[i] && tick) begin
                        nv = mcnt[d][i] + 1;
                        if (nv > MAXV) begin
                            movf[d][i] = 1'b1;
                            nv = (d == 1) ? MAXV : 0;
                        end
                        e.hit[d][i] = (nv != mcnt[d][i]) && (nv == int'(cmp_val));
                        mcnt[d][i] = nv;
                    end
                    e.ovf[d][i] = movf[d][i];
                end
            end
        end
        st_q.push_back(e);
        @(negedge Clk);
    endtask

    task automatic idle_inputs();
        Rst = 1'b0; En = 1'b0; ch_en = '0; ch_clr = '0;
        ld_valid = 1'b0; ld_ch = '0; ld_val = '0; rd_req = 1'b0; rd_ch = '0;
    endtask

    task automatic rd(input int c);
        rd_req = 1'b1;
        rd_ch  = CW'(c);
        step();
        rd_req = 1'b0;
    endtask

    task automatic load(input int c, input int v);
        ld_valid = 1'b1;
        ld_ch    = CW'(c);
        ld_val   = W'(v);
        step();
        ld_valid = 1'b0;
    endtask

    initial begin
        idle_inputs();
        Rst     = 1'b1;
        cmp_val = 8'h80;
`ifdef SYS_COUNTER_PRESCALER_EN
        presc_div = 8'd0;
`endif
        pcnt = 0;
        @(negedge Clk);

        // reset, then count channel 0 for ten cycles and read everything
        step(); step();
        Rst = 1'b0;
        En = 1'b1; ch_en = 5'b00001;
        repeat (10) step();
        ch_en = '0;
        for (int c = 0; c < NCH; c++) rd(c);
        rd(6);
        step();

        // load near the top and increment past it
        load(2, 8'hFE);
        ch_en = 5'b00100;
        repeat (3) step();
        ch_en = '0;
        rd(2);
        ch_clr = 5'b00100; step(); ch_clr = '0;
        rd(2);

        load(1, 8'hFE);
        ch_en = 5'b00010;
        repeat (5) step();
        ch_en = '0;
        rd(1);

        // compare pulse by increment, none by load
        cmp_val = 8'd5;
        ch_clr = 5'b01000; step(); ch_clr = '0;
        ch_en = 5'b01000;
        repeat (7) step();
        ch_en = '0;
        ch_clr = 5'b01000; step(); ch_clr = '0;
        load(3, 5);
        step(); step();

        // clear beats load beats increment; out-of-range load ignored
        ch_clr = 5'b00001; ch_en = 5'b00001;
        ld_valid = 1'b1; ld_ch = '0; ld_val = 8'd7;
        step();
        ch_clr = '0; ch_en = '0; ld_valid = 1'b0;
        rd(0);
        load(0, 7);
        rd(0);
        load(6, 8'h33);
        for (int c = 0; c < NCH; c++) rd(c);

        // reset while a read is requested
        rd_req = 1'b1; rd_ch = '0; Rst = 1'b1; step();
        Rst = 1'b0; rd_req = 1'b0;
        for (int c = 0; c < NCH; c++) rd(c);

        // prescaled counting (plain counting when the prescaler is absent)
        En = 1'b0;
`ifdef SYS_COUNTER_PRESCALER_EN
        presc_div = 8'd3;
`endif
        ch_clr = 5'b00001; step(); ch_clr = '0;
        En = 1'b1; ch_en = 5'b00001;
        repeat (12) step();
        ch_en = '0; En = 1'b0;
        rd(0);
`ifdef SYS_COUNTER_PRESCALER_EN
        presc_div = 8'd0;
`endif
        ch_clr = 5'b00001; step(); ch_clr = '0;
        En = 1'b1; ch_en = 5'b00001;
        repeat (12) step();
        ch_en = '0;
        rd(0);

        // randomized traffic
        En = 1'b0;
`ifdef SYS_COUNTER_PRESCALER_EN
        presc_div = 8'd1;
`endif
        step();
        for (int n = 0; n < 900; n++) begin
            Rst      = ($urandom_range(0, 149) == 0);
            En       = ($urandom_range(0, 7) != 0);
            ch_en    = NCH'($urandom);
            for (int i = 0; i < NCH; i++) ch_clr[i] = ($urandom_range(0, 19) == 0);
            ld_valid = ($urandom_range(0, 5) == 0);
            ld_ch    = CW'($urandom_range(0, 7));
            ld_val   = ($urandom_range(0, 2) == 0) ? W'($urandom) : W'(8'hFB + $urandom_range(0, 4));
            if ($urandom_range(0, 31) == 0) begin
                case ($urandom_range(0, 3))
                    0: cmp_val = 8'h00;
                    1: cmp_val = 8'hFF;
                    2: cmp_val = 8'hFD;
                    default: cmp_val = W'($urandom);
                endcase
            end
            rd_req = ($urandom_range(0, 1) == 1);
            rd_ch  = CW'($urandom_range(0, 7));
            step();
        end

        idle_inputs();
        step(); step();
        repeat (2) @(posedge Clk);
        #2;
        chk("st_q_drain", 0, 64'(st_q.size()), 64'd0);
        chk("rdq_drain", 0, 64'(rdq[0].size()), 64'd0);
        chk("rdq_drain", 1, 64'(rdq[1].size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sys_counter_bank.md
Name: sys_counter_bank

Overview:
- Parametrised multi-channel successor to the single free-running system counter.
- Holds NUM_CH independent WIDTH-bit up-counters. Each channel has its own enable, clear, wrap or saturate policy, a sticky overflow flag and a compare-match pulse.
- Counter values are read through a one-cycle-latency read port.
- Sits beside the system timer: feeds performance/event monitoring and timeout logic.

Parameters:
- NUM_CH, 4: number of counter channels (1..16).
- WIDTH, 32: bits per counter (8..64).
- SATURATE, 0: 0 = wrap at all-ones, 1 = hold at all-ones.
- CH_W, $clog2(NUM_CH) (min 1): channel index width. Derived; not overridden.

Ports:
- Clk  in  1  system clock, all logic on rising edge
- Rst  in  1  synchronous, active-high reset
- En  in  1  global count enable, ANDed with ch_en
- ch_en  in  NUM_CH  per-channel count enable
- ch_clr  in  NUM_CH  per-channel clear pulse; clears count and ovf
- ld_valid  in  1  load strobe
- ld_ch  in  CH_W  channel to load
- ld_val  in  WIDTH  load value
- cmp_val  in  WIDTH  shared compare threshold
- rd_req  in  1  read request
- rd_ch  in  CH_W  channel to read
- rd_valid  out  1  read data valid
- rd_data  out  WIDTH  read data
- ovf  out  NUM_CH  sticky overflow flags
- cmp_hit  out  NUM_CH  one-cycle compare-match pulses

Behaviour:
- Reset:
  - Clk is the clock; Rst is synchronous and active-high.
  - On Rst: all counts = 0, ovf = 0, cmp_hit = 0, rd_valid = 0, rd_data = 0, prescaler = 0.
  - Rst overrides every other input in the same cycle.
- Per-channel priority each cycle: ch_clr > load (ld_valid && ld_ch==i) > increment (En && ch_en[i] && tick).
  - tick = 1 when PRESCALER_EN is undefined.
- Clear: count <= 0, ovf[i] <= 0. A same-cycle load or increment to that channel is dropped.
- Load: count <= ld_val.
  - ovf is unchanged.
  - cmp_hit is not generated by a load.
  - ld_ch >= NUM_CH: load ignored.
- Increment at count == all-ones:
  - SATURATE=0: count <= 0, ovf[i] <= 1.
  - SATURATE=1: count holds all-ones, ovf[i] <= 1 (set on every attempted increment while saturated; sticky anyway).
- Compare:
  - cmp_hit[i] pulses high for exactly one cycle, in the cycle after an increment makes count == cmp_val.
  - No pulse if a saturated channel holds at a value equal to cmp_val.
  - Registered output.
- Read:
  - rd_valid = 1 and rd_data = count[rd_ch] in the cycle after rd_req, sampled before that cycle's update (pre-increment value).
  - Back-to-back requests are accepted every cycle.
  - rd_ch >= NUM_CH returns 0 with rd_valid = 1.
  - rd_data holds its last value while rd_valid = 0.
- Width: all arithmetic is modulo 2^WIDTH. No carry leaves a channel.
- Reset mid-operation: a pending read is discarded; rd_valid = 0 in the next cycle.

Optional Feature:
- Macro SYS_COUNTER_PRESCALER_EN.
- Defined:
  - Adds parameter PRESC_W (default 8) and input presc_div [PRESC_W-1:0].
  - A shared prescaler counts 0..presc_div while En = 1. tick = 1 in the cycle it equals presc_div; it then returns to 0.
  - presc_div = 0 gives a tick every cycle.
  - En = 0 holds the prescaler at 0.
- Undefined: no extra port or parameter; tick is tied to 1.

Decomposition:
- Package sys_counter_pkg:
  - mode localparams MODE_WRAP = 0, MODE_SAT = 1;
  - limits MAX_CH = 16;
  - function ch_width(n) returning max(1, clog2(n)).
- Sub-module sys_counter_ch: one channel holding count, ovf and cmp_hit. It takes inc, clr, ld, ld_val and cmp_val. The bank generates NUM_CH instances and adds the prescaler and read mux.

Test Plan:
1. Rst, then En=1, ch_en=4'b0001 for 10 cycles -> ch0 reads 10, ch1..3 read 0, rd_valid 1 cycle after rd_req.
2. WIDTH=8, SATURATE=0: load ch2=8'hFE, increment 3 cycles -> count 8'h01, ovf[2]=1; ch_clr[2] -> count 0, ovf[2]=0.
3. WIDTH=8, SATURATE=1: load 8'hFE, increment 5 cycles -> count stays 8'hFF, ovf[1]=1.
4. cmp_val=5, increment ch3 from 0 -> cmp_hit[3] high exactly one cycle, after count reaches 5. Loading 5 directly -> no pulse.
5. Same cycle: ch_clr[0], ld_valid with ld_ch=0/ld_val=7, and increment -> count 0. Next cycle: load alone -> 7. Assert Rst during a read -> rd_valid 0, all counts 0.
6. With SYS_COUNTER_PRESCALER_EN defined and presc_div=3: increment ch0 for 12 cycles -> count 3. With presc_div=0 -> count 12.
